// File: rtl/uart_pkg.sv
// Shared constants for the UART byte path: byte width, drain FSM states, busy timeout.
package uart_pkg;
    localparam int BYTE_W       = 8;
    localparam int BUSY_TIMEOUT = 4;
    localparam int TMR_W        = $clog2(BUSY_TIMEOUT);

    typedef enum logic [0:0] {
        DRN_IDLE      = 1'b0,
        DRN_WAIT_BUSY = 1'b1
    } drn_state_t;
endpackage

// File: rtl/byte_fifo_core.sv
// Circular byte buffer with an explicit occupancy register and push/pop/drop arbitration.
// Latency: a push shows in level/empty/full one clock after its edge; head follows rd_ptr.
// Backpressure: none upstream; a push into a full buffer without a same-cycle pop is dropped.
module byte_fifo_core
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   pop,
    output logic [BYTE_W-1:0]      head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              do_push;
    logic              do_pop;

    // A pop in the same cycle frees the slot, so a full buffer still accepts the write.
    assign do_pop  = pop && !empty;
    assign do_push = wr_valid && (!full || do_pop);
    assign drop    = wr_valid && full && !do_pop;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == LVL_W'(DEPTH));
        end
    end

    // Storage is deliberately left out of reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_byte_fifo.sv
// Elastic byte buffer between a UART receiver and transmitter, with overflow accounting.
// Latency: write strobe to tx_en is 2 clocks on an empty buffer with the transmitter ready.
// Backpressure: one tx_en per transmitter busy period, only while tx_rdy; excess writes are counted.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   tx_rdy,
    output logic                   tx_en,
    output logic [BYTE_W-1:0]      tx_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic [CNT_W-1:0]       drop_cnt
);
    drn_state_t        state;
    drn_state_t        state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic              pop;
    logic              drop;
    logic [BYTE_W-1:0] head;

    byte_fifo_core #(
        .DEPTH (DEPTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .pop      (pop),
        .head     (head),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .drop     (drop)
    );

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pop       = 1'b0;
        case (state)
            DRN_IDLE: begin
                tmr_nxt = '0;
                if (!empty && tx_rdy) begin
                    pop       = 1'b1;
                    state_nxt = DRN_WAIT_BUSY;
                end
            end
            DRN_WAIT_BUSY: begin
                // Leave on the busy edge, or after the guard in case en was ignored.
                if (!tx_rdy || tmr == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    state_nxt = DRN_IDLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: state_nxt = DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DRN_IDLE;
            tmr     <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            tx_en <= pop;
            if (pop) tx_data <= head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboarded bench for uart_byte_fifo: a queue model decides accept/drop and byte order,
// a negedge monitor compares every tx_en byte and the status outputs against it.
module tb_uart_byte_fifo;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             tx_rdy = 1'b0;
    logic             clr_overflow = 1'b0;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic [4:0]       level;
    logic             empty;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    uart_byte_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .tx_rdy       (tx_rdy),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         exp_drop = 0;
    int         en_cnt = 0;
    int         en_times[$];
    logic       p_wr = 1'b0, p_clr = 1'b0, p_rdy = 1'b0, prev_en = 1'b0;
    logic [7:0] p_dat = 8'h00;
    logic [7:0] exp_b;
    int         before_n;
    int         stall = 0;

    // Monitor: resolves the inputs sampled at the previous rising edge against what came out.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_drop = 0;
            p_wr = 1'b0; p_clr = 1'b0; p_rdy = 1'b0; prev_en = 1'b0; stall = 0;
            chk("rst_tx_en", tx_en, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_level", level, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
        end else begin
            before_n = exp_q.size();
            if (tx_en) begin
                en_cnt++;
                en_times.push_back(cyc);
                chk("en_while_rdy_low", p_rdy, 1);
                chk("en_single_cycle", prev_en, 0);
                if (exp_q.size() == 0) begin
                    chk("en_with_model_empty", 1, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_data", tx_data, exp_b);
                end
            end
            if (before_n > 0 && p_rdy && !tx_en) stall++;
            else stall = 0;
            if (stall > 5) begin
                chk("drain_stalled", stall, 5);
                stall = 0;
            end
            if (p_wr) begin
                if (before_n < DEPTH || tx_en) begin
                    exp_q.push_back(p_dat);
                end else begin
                    exp_ovf = 1'b1;
                    if (exp_drop < CNT_MAX) exp_drop++;
                end
            end
            if (p_clr) begin
                exp_ovf = 1'b0;
                exp_drop = 0;
            end
            chk("level", level, exp_q.size());
            chk("empty", empty, exp_q.size() == 0);
            chk("full", full, exp_q.size() == DEPTH);
            chk("overflow", overflow, exp_ovf);
            chk("drop_cnt", drop_cnt, exp_drop);
            prev_en = tx_en;
            p_wr  = wr_valid;
            p_dat = wr_data;
            p_clr = clr_overflow;
            p_rdy = tx_rdy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Transmitter model: rdy falls one cycle after en and stays low for 10 cycles.
    task automatic drain_emu(int n);
        int got = 0;
        int guard = 0;
        tx_rdy = 1'b1;
        while (got < n && guard < 3000) begin
            tick();
            guard++;
            if (tx_en) begin
                got++;
                tick();
                tx_rdy = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                tx_rdy = 1'b1;
            end
        end
        chk("drain_count", got, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int e0;
        int w;
        tx_rdy = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Single byte: 2-clock latency, level 0->1->0
        chk("single_lvl0", level, 0);
        wr_valid = 1'b1; wr_data = 8'h41; t0 = cyc;
        tick();
        wr_valid = 1'b0;
        chk("single_lvl1", level, 1);
        chk("single_no_en_yet", tx_en, 0);
        tick();
        chk("single_en", tx_en, 1);
        chk("single_latency", cyc - t0, 2);
        chk("single_data", tx_data, 8'h41);
        chk("single_lvl_back", level, 0);
        repeat (6) tick();

        // Burst while transmitter busy
        tx_rdy = 1'b0;
        tick();
        e0 = en_cnt;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        tick();
        chk("burst_level", level, 5);
        chk("burst_no_en", en_cnt - e0, 0);
        drain_emu(5);
        chk("burst_en_total", en_cnt - e0, 5);

        // Overflow by DEPTH+3 writes
        tx_rdy = 1'b0;
        tick();
        e0 = en_cnt;
        for (int i = 0; i < DEPTH + 3; i++) write_byte(8'(8'h80 + i));
        tick();
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop_cnt", drop_cnt, 3);
        drain_emu(DEPTH);
        repeat (8) tick();
        chk("ovf_only_depth", en_cnt - e0, DEPTH);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_flag", overflow, 0);
        chk("clr_cnt", drop_cnt, 0);

        // Saturation, then clear coinciding with a drop
        tx_rdy = 1'b0;
        for (int i = 0; i < DEPTH + CNT_MAX + 5; i++) write_byte(8'($urandom));
        tick();
        chk("sat_drop_cnt", drop_cnt, CNT_MAX);
        wr_valid = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1;
        tick();
        wr_valid = 1'b0; clr_overflow = 1'b0;
        chk("clr_wins_flag", overflow, 0);
        chk("clr_wins_cnt", drop_cnt, 0);

        // Full with a simultaneous pop: write accepted
        tx_rdy = 1'b1; wr_valid = 1'b1; wr_data = 8'hC3;
        tick();
        wr_valid = 1'b0; tx_rdy = 1'b0;
        chk("fullpop_en", tx_en, 1);
        chk("fullpop_level", level, DEPTH);
        chk("fullpop_drop", drop_cnt, 0);
        drain_emu(DEPTH);
        repeat (4) tick();

        // Randomised traffic, wraps the pointers many times
        e0 = en_cnt;
        for (int i = 0; i < 800; i++) begin
            wr_valid     = ($urandom_range(0, 9) < 4);
            wr_data      = 8'($urandom);
            tx_rdy       = ($urandom_range(0, 4) != 0);
            clr_overflow = ($urandom_range(0, 63) == 0);
            tick();
        end
        wr_valid = 1'b0; clr_overflow = 1'b0; tx_rdy = 1'b1;
        w = 0;
        while (level != 0 && w < 300) begin tick(); w++; end
        repeat (6) tick();
        chk("rand_drained", level, 0);
        chk("rand_wrapped", (en_cnt - e0) >= 3 * DEPTH, 1);

        // Transmitter ignores en: timeout guard spaces pulses 5 clocks
        tx_rdy = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) write_byte(8'(8'hA0 + i));
        en_times.delete();
        tx_rdy = 1'b1;
        w = 0;
        while (en_times.size() < 3 && w < 100) begin tick(); w++; end
        chk("ign_count", en_times.size(), 3);
        if (en_times.size() >= 3) begin
            chk("ign_gap1", en_times[1] - en_times[0], 5);
            chk("ign_gap2", en_times[2] - en_times[1], 5);
        end
        repeat (8) tick();

        // Reset in WAIT_BUSY with bytes queued
        tx_rdy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h10 + i));
        tx_rdy = 1'b1;
        w = 0;
        while (!tx_en && w < 50) begin tick(); w++; end
        chk("rmd_en_seen", tx_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmd_tx_en", tx_en, 0);
        chk("rmd_level", level, 0);
        chk("rmd_empty", empty, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        e0 = en_cnt;
        repeat (12) tick();
        chk("rmd_no_en", en_cnt - e0, 0);
        write_byte(8'h5A);
        repeat (4) tick();
        chk("rmd_new_en", en_cnt - e0, 1);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
